// File: rtl/outfifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : outfifo_pkg
// Purpose  : Shared constants and the write-qualification rule for the DAQ
//            output FIFO. The track-finder output formatter imports the same
//            package so both sides agree on bit positions and on which
//            words are allowed into the FIFO.
// Contents : C_WIDTH, C_DEPTH_LOG2, C_DAQ_MSB_BIT, C_VALID_BIT,
//            C_DROP_CNT_W, outfifo_qual()
// Revision : 1.0 - initial parametrised release
// ============================================================================
package outfifo_pkg;

  localparam int C_WIDTH       = 50;
  localparam int C_DEPTH_LOG2  = 9;
  localparam int C_DAQ_MSB_BIT = 27;
  localparam int C_VALID_BIT   = 39;
  localparam int C_DROP_CNT_W  = 16;

  // A word is qualified for writing when it is an ordinary word, or when it
  // is a track-info word whose valid flag is set while trigger info is on.
  function automatic logic outfifo_qual(
    input logic wren,
    input logic daq_msb,
    input logic track_valid,
    input logic trig_info_en
  );
    return wren && (!daq_msb || (track_valid && trig_info_en));
  endfunction

endpackage
`default_nettype wire

// File: rtl/outfifo_ram.sv
`default_nettype none
// ============================================================================
// Module   : outfifo_ram
// Purpose  : Simple dual-port storage, WIDTH x 2**DEPTH_LOG2, one write port
//            and one registered read port on the same clock. The array has
//            no reset so it maps onto block RAM.
// Ports    : clk      - clock
//            wr_en    - write strobe
//            wr_addr  - write address
//            wr_data  - write data
//            rd_en    - read strobe; rd_data loads on the following edge
//            rd_addr  - read address
//            rd_data  - registered read data, holds when rd_en is low
// Revision : 1.0 - initial parametrised release
// ============================================================================
module outfifo_ram
  import outfifo_pkg::*;
#(
  parameter int WIDTH      = C_WIDTH,
  parameter int DEPTH_LOG2 = C_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0] mem [0:DEPTH-1];

  // Read-first behaviour: when the FIFO is full and a read and write hit the
  // same address in one cycle, the read must return the old word.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/outfifo_param.sv
`default_nettype none
// ============================================================================
// Module   : outfifo_param
// Purpose  : Single-clock parametrised DAQ output FIFO between the track
//            finder output stage and the readout serialiser. Filters writes
//            through the track-info qualification rule, reports occupancy,
//            a programmable almost-full flag, a sticky overflow flag and a
//            saturating count of qualified words lost to a full FIFO.
// Ports    : clk           - system clock, rising edge
//            rst_n         - asynchronous active-low reset
//            flush         - synchronous clear of contents, count and flags
//            din/wren      - write data / write request
//            trig_info_en  - allows qualified track-info words in
//            af_thresh     - almost-full threshold in words
//            rden          - read request
//            dout          - read data, one cycle after an accepted read
//            dout_valid    - dout was loaded by a read on the last edge
//            empty/full    - occupancy is 0 / DEPTH
//            count         - occupancy in words
//            NoSpaceForDAQ - count >= af_thresh
//            overflow      - sticky: a qualified word was lost to full
//            drop_cnt      - saturating number of lost qualified words
// Revision : 1.0 - initial parametrised release
// ============================================================================
module outfifo_param
  import outfifo_pkg::*;
#(
  parameter int WIDTH       = C_WIDTH,
  parameter int DEPTH_LOG2  = C_DEPTH_LOG2,
  parameter int DAQ_MSB_BIT = C_DAQ_MSB_BIT,
  parameter int VALID_BIT   = C_VALID_BIT,
  parameter int DROP_CNT_W  = C_DROP_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [WIDTH-1:0]      din,
  input  logic                  wren,
  input  logic                  trig_info_en,
  input  logic [DEPTH_LOG2:0]   af_thresh,
  input  logic                  rden,
  output logic [WIDTH-1:0]      dout,
  output logic                  dout_valid,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  NoSpaceForDAQ,
  output logic                  overflow,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  localparam int                    DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   DEPTH_CNT = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);
  localparam logic [DROP_CNT_W-1:0] DROP_ONE  = DROP_CNT_W'(1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count_r;
  logic                  empty_r;
  logic                  full_r;
  logic                  nospace_r;
  logic                  armed_r;
  logic                  overflow_r;
  logic [DROP_CNT_W-1:0] drop_r;
  logic                  dout_valid_r;
  logic                  have_read_r;

  // --------------------------------------------------------------------------
  // Transfer decisions
  // --------------------------------------------------------------------------
  logic                  qual;
  logic                  rd_fire;
  logic                  wr_fire;
  logic                  drop;
  logic [DEPTH_LOG2:0]   count_next;
  logic [WIDTH-1:0]      ram_q;

  assign qual = outfifo_qual(wren, din[DAQ_MSB_BIT], din[VALID_BIT], trig_info_en);

  // flush overrides both ports, so it gates every transfer term.
  assign rd_fire = rden && !empty_r && !flush;
  // A full FIFO still accepts a word when a read frees a slot this cycle.
  assign wr_fire = qual && (!full_r || rd_fire) && !flush;
  assign drop    = qual && full_r && !rd_fire && !flush;

  always_comb begin
    count_next = count_r;
    if (flush) begin
      count_next = '0;
    end else if (wr_fire && !rd_fire) begin
      count_next = count_r + CNT_ONE;
    end else if (rd_fire && !wr_fire) begin
      count_next = count_r - CNT_ONE;
    end
  end

  // --------------------------------------------------------------------------
  // Pointers, occupancy and flags
  // --------------------------------------------------------------------------
  // Flags are derived from count_next so they line up with count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_r   <= '0;
      empty_r   <= 1'b1;
      full_r    <= 1'b0;
      nospace_r <= 1'b0;
      armed_r   <= 1'b0;
    end else begin
      count_r   <= count_next;
      empty_r   <= (count_next == '0);
      full_r    <= (count_next == DEPTH_CNT);
      nospace_r <= (count_next >= af_thresh);
      armed_r   <= 1'b1;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_fire) begin
          wr_ptr <= wr_ptr + PTR_ONE;
        end
        if (rd_fire) begin
          rd_ptr <= rd_ptr + PTR_ONE;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Overflow and drop accounting
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_r <= 1'b0;
      drop_r     <= '0;
    end else if (flush) begin
      overflow_r <= 1'b0;
      drop_r     <= '0;
    end else if (drop) begin
      overflow_r <= 1'b1;
      if (drop_r != {DROP_CNT_W{1'b1}}) begin
        drop_r <= drop_r + DROP_ONE;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read-side status
  // --------------------------------------------------------------------------
  // have_read_r masks the un-reset RAM output register until the first real
  // read, so dout reads as zero out of reset. flush does not clear it, which
  // keeps the last word visible on dout across a flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_valid_r <= 1'b0;
      have_read_r  <= 1'b0;
    end else begin
      dout_valid_r <= rd_fire;
      if (rd_fire) begin
        have_read_r <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Storage
  // --------------------------------------------------------------------------
  outfifo_ram #(
    .WIDTH      (WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_fire),
    .wr_addr (wr_ptr),
    .wr_data (din),
    .rd_en   (rd_fire),
    .rd_addr (rd_ptr),
    .rd_data (ram_q)
  );

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign dout       = have_read_r ? ram_q : '0;
  assign dout_valid = dout_valid_r;
  assign empty      = empty_r;
  assign full       = full_r;
  assign count      = count_r;
  assign overflow   = overflow_r;
  assign drop_cnt   = drop_r;

  // Until the first edge after reset, nospace_r has not seen af_thresh yet;
  // with the FIFO empty the flag is simply whether the threshold is zero.
  assign NoSpaceForDAQ = armed_r ? nospace_r : (af_thresh == '0);

endmodule
`default_nettype wire

// File: tb/tb_outfifo_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_outfifo_param
// Purpose  : Self-checking bench for outfifo_param with a queue-based
//            reference model; small depth and drop counter so the full,
//            overflow and saturation corners are reached quickly.
// Revision : 1.0 - initial release
// ============================================================================
module tb_outfifo_param;

  localparam int W  = 50;
  localparam int DL = 4;
  localparam int DC = 4;
  localparam int D  = 1 << DL;
  localparam int DROP_MAX = (1 << DC) - 1;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic [W-1:0]  din;
  logic          wren;
  logic          trig_info_en;
  logic [DL:0]   af_thresh;
  logic          rden;
  logic [W-1:0]  dout;
  logic          dout_valid;
  logic          empty;
  logic          full;
  logic [DL:0]   count;
  logic          NoSpaceForDAQ;
  logic          overflow;
  logic [DC-1:0] drop_cnt;

  outfifo_param #(
    .WIDTH       (W),
    .DEPTH_LOG2  (DL),
    .DAQ_MSB_BIT (27),
    .VALID_BIT   (39),
    .DROP_CNT_W  (DC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .din           (din),
    .wren          (wren),
    .trig_info_en  (trig_info_en),
    .af_thresh     (af_thresh),
    .rden          (rden),
    .dout          (dout),
    .dout_valid    (dout_valid),
    .empty         (empty),
    .full          (full),
    .count         (count),
    .NoSpaceForDAQ (NoSpaceForDAQ),
    .overflow      (overflow),
    .drop_cnt      (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model
  logic [W-1:0] q[$];
  logic [W-1:0] exp_dout;
  logic         exp_valid;
  logic         exp_ovf;
  int           exp_drops;
  logic         exp_nospace;

  function automatic logic [63:0] obs();
    return {count, empty, full, NoSpaceForDAQ, overflow, drop_cnt, dout_valid, dout};
  endfunction

  function automatic logic [63:0] exp_vec();
    return {5'(q.size()), (q.size() == 0), (q.size() == D), exp_nospace,
            exp_ovf, 4'(exp_drops), exp_valid, exp_dout};
  endfunction

  function automatic logic [W-1:0] plain_word();
    logic [W-1:0] w;
    w = W'({$urandom, $urandom});
    w[27] = 1'b0;
    return w;
  endfunction

  task automatic model_reset();
    q.delete();
    exp_dout    = '0;
    exp_valid   = 1'b0;
    exp_ovf     = 1'b0;
    exp_drops   = 0;
    exp_nospace = (af_thresh == 0);
  endtask

  // Drive one cycle and advance the model by the FIFO's rules.
  task automatic step(input logic [W-1:0] d, input logic we, input logic re,
                      input logic fl);
    logic was_full;
    logic rd;
    logic qual;
    din = d; wren = we; rden = re; flush = fl;
    @(posedge clk);
    was_full = (q.size() == D);
    rd       = re && (q.size() != 0);
    qual     = we && (!d[27] || (d[39] && trig_info_en));
    if (fl) begin
      q.delete();
      exp_ovf   = 1'b0;
      exp_drops = 0;
      exp_valid = 1'b0;
    end else begin
      exp_valid = rd;
      if (rd) exp_dout = q.pop_front();
      if (qual) begin
        if (!was_full || rd) q.push_back(d);
        else begin
          exp_ovf = 1'b1;
          if (exp_drops < DROP_MAX) exp_drops++;
        end
      end
    end
    exp_nospace = (q.size() >= int'(af_thresh));
    #1;
    din = '0; wren = 1'b0; rden = 1'b0; flush = 1'b0;
  endtask

  task automatic do_reset(input logic [DL:0] th);
    rst_n = 1'b0; din = '0; wren = 1'b0; rden = 1'b0; flush = 1'b0;
    af_thresh = th;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    trig_info_en = 1'b0;
    do_reset(5'd0);
    n_cmp++;
    if (obs() !== exp_vec()) begin
      n_bad++; $display("FAIL reset_thr0: got %h want %h", obs(), exp_vec());
    end
    n_cmp++;
    if (NoSpaceForDAQ !== 1'b1) begin
      n_bad++; $display("FAIL reset_nospace: got %b want 1", NoSpaceForDAQ);
    end
    do_reset(5'd20);
    n_cmp++;
    if ({count, empty, full, NoSpaceForDAQ, overflow, drop_cnt, dout_valid, dout}
        !== {5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 50'd0}) begin
      n_bad++; $display("FAIL reset_values: got %h want %h", obs(),
                        {5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 50'd0});
    end
  endtask

  task automatic test_basic();
    for (int i = 1; i <= 3; i++) step(W'(i), 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (count !== 5'd3) begin
      n_bad++; $display("FAIL basic_count3: got %0d want 3", count);
    end
    for (int i = 1; i <= 3; i++) begin
      step('0, 1'b0, 1'b1, 1'b0);
      n_cmp++;
      if (dout !== W'(i) || dout_valid !== 1'b1) begin
        n_bad++; $display("FAIL basic_read%0d: got %h/%b want %h/1", i, dout, dout_valid, W'(i));
      end
    end
    n_cmp++;
    if (count !== 5'd0 || empty !== 1'b1) begin
      n_bad++; $display("FAIL basic_empty: got %0d/%b want 0/1", count, empty);
    end
    step('0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (dout_valid !== 1'b0 || dout !== W'(3)) begin
      n_bad++; $display("FAIL basic_hold: got %h/%b want 3/0", dout, dout_valid);
    end
  endtask

  task automatic test_qual();
    logic [W-1:0] w;
    w = '0; w[27] = 1'b1;
    trig_info_en = 1'b1;
    step(w, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (count !== 5'd0 || drop_cnt !== 4'd0) begin
      n_bad++; $display("FAIL qual_novalid: got %0d/%0d want 0/0", count, drop_cnt);
    end
    w[39] = 1'b1;
    trig_info_en = 1'b0;
    step(w, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (count !== 5'd0 || drop_cnt !== 4'd0) begin
      n_bad++; $display("FAIL qual_trigoff: got %0d/%0d want 0/0", count, drop_cnt);
    end
    trig_info_en = 1'b1;
    step(w, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (count !== 5'd1) begin
      n_bad++; $display("FAIL qual_accept: got %0d want 1", count);
    end
    step('0, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (obs() !== exp_vec()) begin
      n_bad++; $display("FAIL qual_readback: got %h want %h", obs(), exp_vec());
    end
  endtask

  task automatic test_af_full();
    af_thresh = 5'd12;
    for (int i = 1; i <= D; i++) begin
      step(plain_word(), 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (NoSpaceForDAQ !== (i >= 12)) begin
        n_bad++; $display("FAIL af_nospace%0d: got %b want %b", i, NoSpaceForDAQ, (i >= 12));
      end
    end
    n_cmp++;
    if (full !== 1'b1 || count !== 5'd16) begin
      n_bad++; $display("FAIL af_full: got %b/%0d want 1/16", full, count);
    end
    repeat (2) step(plain_word(), 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (overflow !== 1'b1 || drop_cnt !== 4'd2 || count !== 5'd16) begin
      n_bad++; $display("FAIL af_drops: got %b/%0d/%0d want 1/2/16", overflow, drop_cnt, count);
    end
  endtask

  task automatic test_full_rw();
    for (int i = 0; i < 5; i++) begin
      step(plain_word(), 1'b1, 1'b1, 1'b0);
      n_cmp++;
      if (obs() !== exp_vec() || count !== 5'd16 || drop_cnt !== 4'd2) begin
        n_bad++; $display("FAIL fullrw_%0d: got %h want %h", i, obs(), exp_vec());
      end
    end
    for (int i = 0; i < D; i++) begin
      step('0, 1'b0, 1'b1, 1'b0);
      n_cmp++;
      if (obs() !== exp_vec()) begin
        n_bad++; $display("FAIL drain_%0d: got %h want %h", i, obs(), exp_vec());
      end
    end
    step(plain_word(), 1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (count !== 5'd1 || dout_valid !== 1'b0) begin
      n_bad++; $display("FAIL emptyrw: got %0d/%b want 1/0", count, dout_valid);
    end
    step('0, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (obs() !== exp_vec()) begin
      n_bad++; $display("FAIL emptyrw_read: got %h want %h", obs(), exp_vec());
    end
  endtask

  task automatic test_saturate();
    repeat (D) step(plain_word(), 1'b1, 1'b0, 1'b0);
    repeat ((1 << DC) + 3) step(plain_word(), 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (drop_cnt !== 4'd15 || overflow !== 1'b1) begin
      n_bad++; $display("FAIL saturate: got %0d/%b want 15/1", drop_cnt, overflow);
    end
  endtask

  task automatic test_flush();
    logic [W-1:0] held;
    repeat (9) step('0, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (count !== 5'd7 || overflow !== 1'b1) begin
      n_bad++; $display("FAIL flush_pre: got %0d/%b want 7/1", count, overflow);
    end
    held = dout;
    step(plain_word(), 1'b1, 1'b1, 1'b1);
    n_cmp++;
    if ({count, empty, overflow, drop_cnt, dout_valid} !== {5'd0, 1'b1, 1'b0, 4'd0, 1'b0}
        || dout !== held) begin
      n_bad++; $display("FAIL flush_post: got %h want 0,1,0,0,0 dout %h", obs(), held);
    end
    n_cmp++;
    if (obs() !== exp_vec()) begin
      n_bad++; $display("FAIL flush_model: got %h want %h", obs(), exp_vec());
    end
  endtask

  task automatic test_reset_mid();
    af_thresh = 5'd3;
    repeat (5) step(plain_word(), 1'b1, 1'b0, 1'b0);
    step(plain_word(), 1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (obs() !== exp_vec()) begin
      n_bad++; $display("FAIL mid_pre: got %h want %h", obs(), exp_vec());
    end
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if ({count, empty, full, NoSpaceForDAQ, overflow, drop_cnt, dout_valid, dout}
        !== {5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 50'd0}) begin
      n_bad++; $display("FAIL mid_reset: got %h want %h", obs(),
                        {5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 50'd0});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic [W-1:0] w;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) af_thresh = 5'($urandom_range(0, 20));
      trig_info_en = ($urandom_range(0, 3) != 0);
      w = W'({$urandom, $urandom});
      step(w, ($urandom_range(0, 2) != 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 60) == 0));
      n_cmp++;
      if (obs() !== exp_vec()) begin
        n_bad++; $display("FAIL random_%0d: got %h want %h", i, obs(), exp_vec());
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; din = '0; wren = 1'b0; rden = 1'b0;
    trig_info_en = 1'b0; af_thresh = '0;
    test_reset();
    test_basic();
    test_qual();
    test_af_full();
    test_full_rw();
    test_saturate();
    test_flush();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/outfifo_param.md
Name: outfifo_param

Overview:
- Single-clock, parametrised successor of the DAQ output FIFO.
- Buffers DAQ/trigger words between the track-finder output stage and the readout serialiser.
- Keeps the existing write qualification (daq MSB words pass only when the track-valid bit is set and trigger info is enabled).
- Adds:
  - configurable width, depth and bit positions
  - a programmable almost-full threshold
  - an occupancy count
  - a synchronous flush
  - a sticky overflow flag and a saturating drop counter

Parameters:
WIDTH, 50, data word width
DEPTH_LOG2, 9, log2 of FIFO depth (DEPTH = 2**DEPTH_LOG2 words)
DAQ_MSB_BIT, 27, din bit marking a track-info word that needs qualification
VALID_BIT, 39, din bit carrying the track-valid flag
DROP_CNT_W, 16, width of the saturating drop counter

Ports:
clk  input  1  single system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous clear of FIFO contents, count and flags
din  input  WIDTH  write data
wren  input  1  write request
trig_info_en  input  1  enables writing of qualified track-info words
af_thresh  input  DEPTH_LOG2+1  almost-full threshold in words
rden  input  1  read request
dout  output  WIDTH  read data, registered
dout_valid  output  1  dout holds a newly read word this cycle
empty  output  1  FIFO holds zero words
full  output  1  FIFO holds DEPTH words
count  output  DEPTH_LOG2+1  current occupancy
NoSpaceForDAQ  output  1  count >= af_thresh
overflow  output  1  sticky: a qualified write was lost because the FIFO was full
drop_cnt  output  DROP_CNT_W  saturating count of qualified writes lost to full

Behaviour:
- Reset (rst_n low, asynchronous):
  - pointers = 0, count = 0, empty = 1, full = 0, NoSpaceForDAQ = (af_thresh == 0).
  - overflow = 0, drop_cnt = 0, dout = 0, dout_valid = 0.
  - RAM contents are not cleared.
- Qualification:
  - qual = wren && (!din[DAQ_MSB_BIT] || (din[VALID_BIT] && trig_info_en)).
  - Unqualified words are silently discarded and are not counted as drops.
- Read:
  - rd_fire = rden && !empty.
  - dout and dout_valid update on the edge after rd_fire, giving 1-cycle latency.
  - dout holds its last value when there is no read; dout_valid = 0 in that case.
  - Read while empty is ignored and flags nothing.
- Write:
  - wr_fire = qual && (!full || rd_fire).
  - A write to a full FIFO with a simultaneous read is accepted; count is unchanged.
- Drops:
  - When qual && full && !rd_fire, the word is dropped: overflow <= 1 and drop_cnt increments.
  - drop_cnt saturates at all-ones and does not wrap.
- Simultaneous write and read on an empty FIFO: the write is accepted, the read is ignored, and count goes 0 -> 1.
- Count update: count <= count + wr_fire - rd_fire. empty, full and NoSpaceForDAQ are registered and derived from the next count, so they are valid in the same cycle as count.
- Pointers: DEPTH_LOG2 bits each and wrap naturally modulo DEPTH. Full is detected from count, not from pointer compare.
- af_thresh:
  - May change at any time; NoSpaceForDAQ reflects the new value one cycle later.
  - af_thresh > DEPTH means NoSpaceForDAQ never asserts.
- flush:
  - Synchronous; has priority over wren and rden in the same cycle.
  - Next cycle: pointers = 0, count = 0, empty = 1, overflow = 0, drop_cnt = 0, dout_valid = 0. dout is retained.
- Reset asserted mid-operation: immediate return to reset values. Words in flight are lost and no drop is counted.

Decomposition:
- Shared package outfifo_pkg:
  - default WIDTH/DEPTH_LOG2/bit-position constants (DAQ_MSB_BIT, VALID_BIT), shared with the track-finder output formatter.
  - a function computing the qualification term, so that the formatter and this FIFO agree.
- One sub-module, outfifo_ram:
  - simple dual-port RAM, WIDTH x DEPTH, one write port and one registered read port on clk.
  - no reset on the array, so it maps to block RAM.
- Control (pointers, count, flags, drop counter) lives in outfifo_param.

Test Plan:
1. Reset, then write 3 words with din[27] = 0 (0x1, 0x2, 0x3) and read 3 -> dout = 0x1, 0x2, 0x3, each 1 cycle after rden. count goes 3 -> 0 and empty returns to 1.
2. Write with din[27] = 1: din[39] = 0 -> dropped silently (count stays 0, drop_cnt 0). din[39] = 1 with trig_info_en = 0 -> dropped silently. din[39] = 1 with trig_info_en = 1 -> accepted (count 1).
3. DEPTH_LOG2 = 4, af_thresh = 12 -> NoSpaceForDAQ rises in the same cycle count reaches 12. Continue to 16 -> full = 1. Two more qualified writes -> overflow = 1, drop_cnt = 2, count stays 16.
4. Full FIFO with wren and rden together for 5 cycles -> count stays 16, no drops, output order preserved. Then empty FIFO with wren and rden together -> count = 1, dout_valid = 0.
5. Hold qualified writes while full for 2**DROP_CNT_W + 3 cycles (use DROP_CNT_W = 4) -> drop_cnt saturates at 15.
6. FIFO holding 7 words, overflow = 1: assert flush with wren = 1 -> next cycle count = 0, empty = 1, overflow = 0, drop_cnt = 0. Separately, pulse rst_n low mid-burst -> all outputs return to reset values immediately, without waiting for clk.
